sram_access_arbiter: RTL
========================

Name: sram_access_arbiter

Overview:
- Shares the single SRAM_Controller port between three requesters: VGA reader (index 0), UART loader (index 1) and Milestone 1 datapath (index 2).
- Replaces the top-level hard-wired SRAM muxing with a req/gnt handshake, fixed priority, optional VGA preemption, and a drain phase.
- Read data is tagged back to the owner that issued each read.
- Sits between the requester units and SRAM_Controller in the top module.

Parameters:
- READ_LATENCY, 3, cycles from address presented (we_n=1) to valid SRAM_read_data.
- VGA_PREEMPT, 1, when 1 a VGA request revokes a lower-priority grant.
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.

Ports:
- Clock_50  input  1  system clock, 50 MHz.
- Reset  input  1  asynchronous, active-high reset.
- req  input  3  request per requester; bit0 VGA, bit1 UART, bit2 M1.
- gnt  output  3  one-hot grant, registered.
- req_address  input  3*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_write_data  input  3*DATA_W  packed write data.
- req_we_n  input  3  per-requester write enable, active low.
- SRAM_address  output  ADDR_W  to SRAM_Controller.
- SRAM_write_data  output  DATA_W  to SRAM_Controller.
- SRAM_we_n  output  1  to SRAM_Controller.
- SRAM_read_data  input  DATA_W  from SRAM_Controller.
- rd_data  output  DATA_W  SRAM_read_data passed through.
- rd_valid  output  3  one-hot; read data belongs to requester i this cycle.
- owner  output  2  current owner index; 2'd3 = none.

Behaviour:
- Reset, asynchronous and immediate: gnt=0, owner=3, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, rd_valid=0, read pipe cleared, FSM to S_ARB_IDLE.
- S_ARB_IDLE: no grant.
  - If any req is high, select the lowest index set (priority 0>1>2).
  - Next cycle: gnt[sel]=1, owner=sel, go to S_ARB_GRANT.
  - Latency req->gnt = 1 cycle.
- S_ARB_GRANT: SRAM_address/write_data/we_n are a combinational mux of the owner's inputs. Ungranted inputs are ignored.
  - Owner drops req: gnt cleared next cycle, go to S_ARB_DRAIN.
  - VGA_PREEMPT=1, req[0]=1 and owner!=0: gnt cleared next cycle, go to S_ARB_DRAIN. The preempted requester keeps req high and waits for regrant. Any access it presents in the revoke cycle is still issued.
- S_ARB_DRAIN: SRAM_we_n forced 1, address held at last value.
  - Counter runs READ_LATENCY cycles so in-flight reads return to the correct owner, then go to S_ARB_IDLE.
  - Arbitration in IDLE is fresh, so a preempted requester competes again normally.
- Outside S_ARB_GRANT: SRAM_we_n=1 always, SRAM_write_data=0.
- Read tag pipe: shift register depth READ_LATENCY of {valid, owner}.
  - Pushes valid=1 on each GRANT cycle where the owner's we_n=1; otherwise pushes valid=0.
  - rd_valid[i] = pipe tail valid && tag==i.
  - Writes never produce rd_valid.
- Simultaneous events:
  - Owner drop and higher-priority req in the same cycle: normal DRAIN, then VGA wins in IDLE.
  - All three req in IDLE: VGA granted.
  - req dropped in the same cycle gnt rises: one cycle of grant is issued, then DRAIN.
- gnt is never asserted to two requesters. At most one bit of rd_valid is high.
- Requester contract: an access counts only in cycles with gnt[i]=1 at the clock edge; the requester advances its address on those cycles only.

Optional Feature:
- ARB_STATS_EN: adds output grant_cycles (3x32, packed) counting GRANT cycles per owner, saturating at 32'hFFFFFFFF, cleared by Reset.
- Without the macro: no port, no counters.

Decomposition:
- Package sram_arb_pkg:
  - arb_state_type enum {S_ARB_IDLE, S_ARB_GRANT, S_ARB_DRAIN}
  - requester index constants REQ_VGA=0, REQ_UART=1, REQ_M1=2, OWNER_NONE=3
- Sub-module sram_read_tag_pipe: parameterised depth/width shift register producing the rd_valid tags.

Test Plan:
- Reset mid-grant: M1 owns and is writing; assert Reset -> same cycle SRAM_we_n=1, gnt=000, owner=3, rd_valid=000.
- Single requester: M1 req at cycle 0, reads 0x100..0x103 -> gnt[2] at cycle 1; rd_valid[2] at cycles 1+READ_LATENCY..4+READ_LATENCY with data from 0x100..0x103.
- Priority: req=111 in IDLE -> gnt=001. VGA drops -> after 3 drain cycles gnt=010.
- Preemption: UART writes 0x0ABC to 0x00010 while holding; VGA req rises -> UART gnt drops next cycle, 3 drain cycles with we_n=1, then gnt=001. After VGA releases, UART regranted.
- Read tagging across switch: VGA read of 146944 then release; UART granted after drain -> rd_valid=001 for the VGA read, and never to UART.
- ARB_STATS_EN: M1 holds for 100 cycles -> grant_cycles[2]=100, others 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter.
// Latency: n/a (types, constants and a pure priority-select function only).
// Backpressure: n/a.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_ARB_IDLE,
        S_ARB_GRANT,
        S_ARB_DRAIN
    } arb_state_type;

    localparam logic [1:0] REQ_VGA    = 2'd0;
    localparam logic [1:0] REQ_UART   = 2'd1;
    localparam logic [1:0] REQ_M1     = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    // Fixed priority: lowest requester index wins.
    function automatic logic [1:0] pick_owner(input logic [2:0] r);
        logic [1:0] sel;
        sel = OWNER_NONE;
        if (r[0])      sel = REQ_VGA;
        else if (r[1]) sel = REQ_UART;
        else if (r[2]) sel = REQ_M1;
        return sel;
    endfunction

endpackage

// File: rtl/sram_read_tag_pipe.sv
// Shift register carrying {valid, tag} alongside reads in flight to the SRAM.
// Latency: DEPTH cycles from push to tail.
// Backpressure: none; shifts every cycle, the SRAM cannot stall.
//
// Ports: Clock_50/Reset (async active-high), push_vld/push_tag (head),
//        tail_vld/tail_tag (entry pushed DEPTH cycles ago).
module sram_read_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 2
) (
    input  logic             Clock_50,
    input  logic             Reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_tag,
    output logic             tail_vld,
    output logic [WIDTH-1:0] tail_tag
);

    logic             vld_sr [DEPTH];
    logic [WIDTH-1:0] tag_sr [DEPTH];

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_sr[i] <= 1'b0;
                tag_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= push_vld;
            tag_sr[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign tail_vld = vld_sr[DEPTH-1];
    assign tail_tag = tag_sr[DEPTH-1];

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one SRAM_Controller port between VGA (0), UART (1) and M1 (2) with req/gnt.
// Latency: req->gnt 1 cycle from idle; owner access is muxed combinationally to SRAM.
// Backpressure: a requester waits with req high until gnt; ownership change drains reads.
//
// Ports: Clock_50, Reset (async active-high); req/gnt/owner handshake;
//        req_address/req_write_data/req_we_n packed per requester (index i at slice i);
//        SRAM_address/SRAM_write_data/SRAM_we_n/SRAM_read_data toward SRAM_Controller;
//        rd_data/rd_valid return read data tagged with the issuing requester.
// Optional macro ARB_STATS_EN adds grant_cycles (3 x 32-bit saturating GRANT counters).
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 3,
    parameter int VGA_PREEMPT  = 1,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16
) (
    input  logic                Clock_50,
    input  logic                Reset,
    input  logic [2:0]          req,
    output logic [2:0]          gnt,
    input  logic [3*ADDR_W-1:0] req_address,
    input  logic [3*DATA_W-1:0] req_write_data,
    input  logic [2:0]          req_we_n,
    output logic [ADDR_W-1:0]   SRAM_address,
    output logic [DATA_W-1:0]   SRAM_write_data,
    output logic                SRAM_we_n,
    input  logic [DATA_W-1:0]   SRAM_read_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic [2:0]          rd_valid,
    output logic [1:0]          owner
`ifdef ARB_STATS_EN
    ,
    output logic [3*32-1:0]     grant_cycles
`endif
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    arb_state_type     state;
    logic [CNT_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0] last_address;
    logic [1:0]        sel;
    logic              in_grant;
    logic              preempt;

    logic              own_req;
    logic              own_we_n;
    logic [ADDR_W-1:0] own_address;
    logic [DATA_W-1:0] own_wdata;

    logic              tail_vld;
    logic [1:0]        tail_tag;

    // Owner's request view; only meaningful while in GRANT.
    always_comb begin
        own_req     = 1'b0;
        own_we_n    = 1'b1;
        own_address = '0;
        own_wdata   = '0;
        case (owner)
            REQ_VGA: begin
                own_req     = req[0];
                own_we_n    = req_we_n[0];
                own_address = req_address[0 +: ADDR_W];
                own_wdata   = req_write_data[0 +: DATA_W];
            end
            REQ_UART: begin
                own_req     = req[1];
                own_we_n    = req_we_n[1];
                own_address = req_address[ADDR_W +: ADDR_W];
                own_wdata   = req_write_data[DATA_W +: DATA_W];
            end
            REQ_M1: begin
                own_req     = req[2];
                own_we_n    = req_we_n[2];
                own_address = req_address[2*ADDR_W +: ADDR_W];
                own_wdata   = req_write_data[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    assign sel      = pick_owner(req);
    assign in_grant = (state == S_ARB_GRANT);
    assign preempt  = (VGA_PREEMPT != 0) && req[REQ_VGA] && (owner != REQ_VGA);

    // Outside GRANT the port is parked: no writes, address frozen.
    assign SRAM_address    = in_grant ? own_address : last_address;
    assign SRAM_write_data = in_grant ? own_wdata   : '0;
    assign SRAM_we_n       = in_grant ? own_we_n    : 1'b1;
    assign rd_data         = SRAM_read_data;

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state        <= S_ARB_IDLE;
            gnt          <= '0;
            owner        <= OWNER_NONE;
            drain_cnt    <= '0;
            last_address <= '0;
        end else begin
            case (state)
                S_ARB_IDLE: begin
                    if (|req) begin
                        gnt   <= 3'b001 << sel;
                        owner <= sel;
                        state <= S_ARB_GRANT;
                    end
                end
                S_ARB_GRANT: begin
                    last_address <= own_address;
                    // The access presented in this cycle is still issued; the
                    // grant disappears from the next cycle on.
                    if (!own_req || preempt) begin
                        gnt       <= '0;
                        owner     <= OWNER_NONE;
                        drain_cnt <= '0;
                        state     <= S_ARB_DRAIN;
                    end
                end
                S_ARB_DRAIN: begin
                    // Wait out the read latency so every in-flight read
                    // returns before anyone else can issue.
                    if (drain_cnt == CNT_W'(READ_LATENCY - 1)) begin
                        state <= S_ARB_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= S_ARB_IDLE;
            endcase
        end
    end

    sram_read_tag_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (2)
    ) u_tag_pipe (
        .Clock_50 (Clock_50),
        .Reset    (Reset),
        .push_vld (in_grant && own_we_n),
        .push_tag (owner),
        .tail_vld (tail_vld),
        .tail_tag (tail_tag)
    );

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < 3; i++) begin
            rd_valid[i] = tail_vld && (tail_tag == 2'(i));
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] stat_cnt [3];

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) stat_cnt[i] <= '0;
        end else if (in_grant) begin
            for (int i = 0; i < 3; i++) begin
                if (owner == 2'(i) && stat_cnt[i] != 32'hFFFF_FFFF) begin
                    stat_cnt[i] <= stat_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign grant_cycles = {stat_cnt[2], stat_cnt[1], stat_cnt[0]};
`endif

endmodule
